// File: rtl/divider_monitor.sv
// Period/lock/error checker for two divided clocks sampled in the clk domain.
// Each channel synchronises its input, measures rise-to-rise spacing and tracks lock.
`timescale 1ns/1ps
module divider_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP1       = 2,
    parameter int EXP2       = 4,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic             y1,
    input  logic             y2,
    output logic [CNT_W-1:0] period1,
    output logic [CNT_W-1:0] period2,
    output logic             p1_valid,
    output logic             p2_valid,
    output logic             lock1,
    output logic             lock2,
    output logic             err1,
    output logic             err2
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW:0]      LOCK_C = LOCK_COUNT[MW:0];
    localparam logic [CNT_W-1:0] TO_C   = TIMEOUT[CNT_W-1:0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            localparam int EXP_I = (gi == 0) ? EXP1 : EXP2;
            localparam logic [CNT_W-1:0] EXP_C = EXP_I[CNT_W-1:0];

            logic             y_raw, y_q, y_qq, rise;
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] period_reg, period_next;
            logic [MW-1:0]    match_reg, match_next;
            logic [MW:0]      match_inc;
            logic             lock_reg, lock_next;
            logic             err_reg, err_next, err_set;
            logic             valid_reg, valid_next;

            assign y_raw     = (gi == 0) ? y1 : y2;
            assign rise      = y_q & ~y_qq;
            assign match_inc = {1'b0, match_reg} + 1'b1;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    y_q        <= 1'b0;
                    y_qq       <= 1'b0;
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    period_reg <= '0;
                    match_reg  <= '0;
                    lock_reg   <= 1'b0;
                    err_reg    <= 1'b0;
                    valid_reg  <= 1'b0;
                end else begin
                    y_q        <= y_raw;
                    y_qq       <= y_q;
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    period_reg <= period_next;
                    match_reg  <= match_next;
                    lock_reg   <= lock_next;
                    err_reg    <= err_next;
                    valid_reg  <= valid_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                period_next = period_reg;
                match_next  = match_reg;
                lock_next   = lock_reg;
                valid_next  = 1'b0;
                err_set     = 1'b0;
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    match_next = '0;
                    lock_next  = 1'b0;
                end else if (state_reg == IDLE) begin
                    cnt_next   = '0;
                    match_next = '0;
                    lock_next  = 1'b0;
                    // The first rise only arms the counter; no period exists yet.
                    if (rise) begin
                        state_next = MEASURE;
                        cnt_next   = CNT_W'(1);
                    end
                end else if (rise) begin
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    cnt_next    = CNT_W'(1);
                    if (cnt_reg == EXP_C) begin
                        if (match_inc >= LOCK_C) begin
                            match_next = LOCK_C[MW-1:0];
                            lock_next  = 1'b1;
                        end else begin
                            match_next = match_inc[MW-1:0];
                        end
                    end else begin
                        match_next = '0;
                        lock_next  = 1'b0;
                        err_set    = 1'b1;
                    end
                end else if (cnt_reg == TO_C) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    match_next = '0;
                    lock_next  = 1'b0;
                    err_set    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // A new error in the clearing cycle must not be lost.
                err_next = (err_reg & ~clr_err) | err_set;
            end
        end
    endgenerate

    assign period1  = g_ch[0].period_reg;
    assign period2  = g_ch[1].period_reg;
    assign p1_valid = g_ch[0].valid_reg;
    assign p2_valid = g_ch[1].valid_reg;
    assign lock1    = g_ch[0].lock_reg;
    assign lock2    = g_ch[1].lock_reg;
    assign err1     = g_ch[0].err_reg;
    assign err2     = g_ch[1].err_reg;
endmodule

// File: tb/tb_divider_monitor.sv
// Bench for divider_monitor: directed scenarios plus randomized waveforms, all
// outputs compared every cycle against a time-difference based reference model.
`timescale 1ns/1ps
module tb_divider_monitor;
    localparam int CNT_W = 16, EXP1 = 2, EXP2 = 4, LC = 3, TO = 1024;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr_err = 1'b0, y1 = 1'b0, y2 = 1'b0;
    logic [CNT_W-1:0] period1, period2;
    logic p1_valid, p2_valid, lock1, lock2, err1, err2;

    divider_monitor #(.CNT_W(CNT_W), .EXP1(EXP1), .EXP2(EXP2), .LOCK_COUNT(LC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .y1(y1), .y2(y2),
        .period1(period1), .period2(period2), .p1_valid(p1_valid), .p2_valid(p2_valid),
        .lock1(lock1), .lock2(lock2), .err1(err1), .err2(err2)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a rise seen on the sampled input acts one edge later;
    // periods and timeouts are differences between edge indices.
    int m_t, m_period[2], m_match[2], m_last_rise[2];
    bit m_valid[2], m_lock[2], m_err[2], m_armed[2], m_pend[2], m_last_s[2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_period[ch] = 0; m_match[ch] = 0; m_last_rise[ch] = 0;
                m_valid[ch] = 0; m_lock[ch] = 0; m_err[ch] = 0;
                m_armed[ch] = 0; m_pend[ch] = 0; m_last_s[ch] = 0;
            end
        end else begin
            m_t++;
            for (int ch = 0; ch < 2; ch++) begin
                bit s, act, set;
                int p, expv;
                s    = (ch == 0) ? y1 : y2;
                expv = (ch == 0) ? EXP1 : EXP2;
                act  = m_pend[ch];
                m_pend[ch]   = s && !m_last_s[ch];
                m_last_s[ch] = s;
                set = 0;
                m_valid[ch] = 0;
                if (!en) begin
                    m_armed[ch] = 0; m_match[ch] = 0; m_lock[ch] = 0;
                end else if (!m_armed[ch]) begin
                    m_match[ch] = 0; m_lock[ch] = 0;
                    if (act) begin
                        m_armed[ch] = 1; m_last_rise[ch] = m_t;
                    end
                end else if (act) begin
                    p = m_t - m_last_rise[ch];
                    m_last_rise[ch] = m_t;
                    m_period[ch] = p;
                    m_valid[ch]  = 1;
                    if (p == expv) begin
                        m_match[ch] = (m_match[ch] + 1 > LC) ? LC : m_match[ch] + 1;
                        if (m_match[ch] >= LC) m_lock[ch] = 1;
                    end else begin
                        m_match[ch] = 0; m_lock[ch] = 0; set = 1;
                    end
                end else if (m_t - m_last_rise[ch] == TO) begin
                    m_armed[ch] = 0; m_match[ch] = 0; m_lock[ch] = 0; set = 1;
                end
                m_err[ch] = (m_err[ch] && !clr_err) || set;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_period1", period1, m_period[0]);
        chk("cmp_period2", period2, m_period[1]);
        chk("cmp_p1_valid", p1_valid, m_valid[0]);
        chk("cmp_p2_valid", p2_valid, m_valid[1]);
        chk("cmp_lock1", lock1, m_lock[0]);
        chk("cmp_lock2", lock2, m_lock[1]);
        chk("cmp_err1", err1, m_err[0]);
        chk("cmp_err2", err2, m_err[1]);
    end

    // Waveform generator state, one entry per channel.
    bit lvl[2], hold[2];
    int rem[2], hi[2], lo[2], stretch[2], rcount[2], npulse[2], lock_at[2];
    bit lock_seen[2];

    task automatic cyc();
        for (int ch = 0; ch < 2; ch++) begin
            if (hold[ch]) begin
                lvl[ch] = 0; rem[ch] = 0;
            end else if (rem[ch] == 0) begin
                lvl[ch] = !lvl[ch];
                if (lvl[ch]) begin
                    rem[ch] = hi[ch] - 1 + stretch[ch];
                    stretch[ch] = 0;
                    rcount[ch]++;
                end else begin
                    rem[ch] = lo[ch] - 1;
                end
            end else begin
                rem[ch]--;
            end
        end
        y1 = lvl[0];
        y2 = lvl[1];
        @(negedge clk);
        if (p1_valid) npulse[0]++;
        if (p2_valid) npulse[1]++;
        if (lock1 && !lock_seen[0]) begin lock_seen[0] = 1; lock_at[0] = npulse[0]; end
        if (lock2 && !lock_seen[1]) begin lock_seen[1] = 1; lock_at[1] = npulse[1]; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period1"}, period1, 0);
        chk({tag, "_period2"}, period2, 0);
        chk({tag, "_valid"}, {p1_valid, p2_valid}, 0);
        chk({tag, "_lock"}, {lock1, lock2}, 0);
        chk({tag, "_err"}, {err1, err2}, 0);
    endtask

    initial begin
        bit found;
        hi = '{1, 2}; lo = '{1, 2}; hold = '{1, 1};
        lvl = '{0, 0}; rem = '{0, 0}; stretch = '{0, 0};
        rcount = '{0, 0}; npulse = '{0, 0}; lock_at = '{0, 0}; lock_seen = '{0, 0};

        // T1: reset, then idle without edges
        repeat (2) @(negedge clk);
        chk_zero("t1_reset");
        rst = 1; en = 1;
        repeat (20) cyc();
        chk_zero("t1_idle");

        // T2: nominal waveforms, lock on third valid period
        hold = '{0, 0};
        repeat (30) cyc();
        chk("t2_lock1_on_pulse", lock_at[0], 3);
        chk("t2_lock2_on_pulse", lock_at[1], 3);
        chk("t2_period1", period1, 2);
        chk("t2_period2", period2, 4);
        chk("t2_locks", {lock1, lock2}, 3);
        chk("t2_errs", {err1, err2}, 0);

        // T3: one stretched y2 high phase
        stretch[1] = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (p2_valid && period2 != 4) found = 1;
        end
        chk("t3_mismatch_seen", found, 1);
        chk("t3_period2", period2, 5);
        chk("t3_err2", err2, 1);
        chk("t3_lock2", lock2, 0);
        repeat (30) cyc();
        chk("t3_relock2", lock2, 1);
        chk("t3_err2_sticky", err2, 1);
        clr_err = 1; cyc(); clr_err = 0;
        chk("t3_err2_cleared", err2, 0);

        // T4: y1 held low past the timeout, then restarted
        hold[0] = 1;
        repeat (1100) cyc();
        chk("t4_lock1", lock1, 0);
        chk("t4_err1", err1, 1);
        hold[0] = 0;
        rcount[0] = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (p1_valid) found = 1;
        end
        chk("t4_valid_seen", found, 1);
        chk("t4_rises_before_valid", rcount[0], 2);
        chk("t4_period1", period1, 2);

        // T5: clr_err coincides with a y1 mismatch
        repeat (10) cyc();
        clr_err = 1; cyc(); clr_err = 0;
        chk("t5_err1_cleared", err1, 0);
        stretch[0] = 1;
        rcount[0] = 0;
        for (int i = 0; i < 20 && rcount[0] < 2; i++) cyc();
        chk("t5_rises", rcount[0], 2);
        clr_err = 1; cyc(); clr_err = 0;
        chk("t5_valid", p1_valid, 1);
        chk("t5_period1", period1, 3);
        chk("t5_err1_set_wins", err1, 1);

        // T6: drop en mid-period, then asynchronous reset mid-period
        repeat (20) cyc();
        en = 0; cyc();
        chk("t6_en_locks", {lock1, lock2}, 0);
        chk("t6_en_period1", period1, 2);
        chk("t6_en_period2", period2, 4);
        repeat (3) cyc();
        en = 1;
        repeat (5) cyc();
        @(posedge clk);
        #2 rst = 0;
        #1 chk_zero("t6_async");
        @(negedge clk);
        rst = 1;

        // Randomized waveforms, enable drops and error clears
        for (int r = 0; r < 60; r++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 1) == 0) begin
                    hi[ch] = (ch == 0) ? 1 : 2;
                    lo[ch] = hi[ch];
                end else begin
                    hi[ch] = $urandom_range(1, 4);
                    lo[ch] = $urandom_range(1, 4);
                end
            end
            for (int i = 0; i < 40; i++) begin
                en      = ($urandom_range(0, 49) != 0);
                clr_err = ($urandom_range(0, 19) == 0);
                cyc();
            end
        end
        en = 1; clr_err = 0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
